// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: PC sequencer states, request vector
// and the fixed exception/reset addresses.
package cpu_pkg;

  localparam logic [31:0] RESET_PC        = 32'h8000_0000;
  localparam logic [31:0] EXC_VEC_DFLT    = 32'h8000_0180;
  localparam logic [31:0] REFILL_VEC_DFLT = 32'h8000_0000;

  typedef enum logic [1:0] {BOOT, RUN, PEND, FLUSH} pcs_state_t;

  // One bit per PC source, highest priority first.
  typedef struct packed {
    logic exc;
    logic eret;
    logic pend;
    logic br;
    logic seq;
  } pcs_req_t;

  // A fault in a delay slot restarts at the branch that owns the slot.
  function automatic logic [31:0] epc_of(input logic [31:0] fpc, input logic bd);
    return bd ? fpc - 32'd4 : fpc;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Priority select of the next PC and its write enable from the request vector.
module pc_next_mux
  import cpu_pkg::*;
(
  input  pcs_req_t    req_i,
  input  logic        rdy_i,
  input  logic [31:0] exc_vec_i,
  input  logic [31:0] epc_in_i,
  input  logic [31:0] pend_target_i,
  input  logic [31:0] br_target_i,
  input  logic [31:0] pc_i,
  output logic [31:0] npc_o,
  output logic        pc_we_o
);

  always_comb begin
    npc_o   = pc_i + 32'd4;
    pc_we_o = 1'b0;
    if (req_i.exc) begin
      npc_o   = exc_vec_i;
      pc_we_o = 1'b1;
    end else if (req_i.eret) begin
      npc_o   = epc_in_i;
      pc_we_o = 1'b1;
    end else if (req_i.pend) begin
      npc_o   = pend_target_i;
      pc_we_o = rdy_i;
    end else if (req_i.br) begin
      npc_o   = br_target_i;
      pc_we_o = rdy_i;
    end else if (req_i.seq) begin
      pc_we_o = rdy_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: arbitrates sequential, branch, exception and ERET
// redirects, and holds a branch that resolves while fetch cannot advance.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] EXC_VEC    = EXC_VEC_DFLT,
  parameter logic [31:0] REFILL_VEC = REFILL_VEC_DFLT
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] pc_i,
  input  logic        if_ready_i,
  input  logic        stall_i,
  input  logic        br_req_i,
  input  logic [31:0] br_target_i,
  input  logic        exc_i,
  input  logic        exc_refill_i,
  input  logic [31:0] exc_pc_i,
  input  logic        exc_bd_i,
  input  logic        eret_i,
  input  logic [31:0] epc_in_i,
  output logic [31:0] npc_o,
  output logic        pc_we_o,
  output logic        flush_o,
  output logic [31:0] epc_o,
  output logic        epc_we_o
);

  pcs_state_t  state_q, state_d;
  logic [31:0] pend_q, pend_d;
  pcs_req_t    req;
  logic        rdy;
  logic [31:0] mux_npc;
  logic        mux_we;

  assign rdy = if_ready_i & ~stall_i;

  // A branch is only live in RUN: PEND already holds it, FLUSH squashed it.
  always_comb begin
    req      = '0;
    req.exc  = exc_i;
    req.eret = eret_i;
    req.pend = (state_q == PEND);
    req.br   = br_req_i & (state_q == RUN);
    req.seq  = (state_q != BOOT);
  end

  pc_next_mux u_mux (
    .req_i        (req),
    .rdy_i        (rdy),
    .exc_vec_i    (exc_refill_i ? REFILL_VEC : EXC_VEC),
    .epc_in_i     (epc_in_i),
    .pend_target_i(pend_q),
    .br_target_i  (br_target_i),
    .pc_i         (pc_i),
    .npc_o        (mux_npc),
    .pc_we_o      (mux_we)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= BOOT;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    if (exc_i || eret_i) begin
      state_d = FLUSH;
      pend_d  = '0;
    end else begin
      case (state_q)
        BOOT:  state_d = RUN;
        RUN:   if (br_req_i && !rdy) begin
                 state_d = PEND;
                 pend_d  = br_target_i;
               end
        PEND:  if (rdy) state_d = RUN;
        FLUSH: state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    npc_o    = RESET_PC;
    pc_we_o  = 1'b0;
    flush_o  = 1'b0;
    epc_o    = '0;
    epc_we_o = 1'b0;
    if (clrn) begin
      npc_o    = mux_npc;
      pc_we_o  = mux_we;
      flush_o  = exc_i | eret_i;
      epc_we_o = exc_i;
      if (exc_i) epc_o = epc_of(exc_pc_i, exc_bd_i);
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the pipelined CPU front end. Each cycle it chooses the value and write enable for the virtual program counter register: sequential, branch/jump, exception vector or ERET return. It arbitrates between these requests, holds a redirect that arrives during a stall, and produces the EPC write for exceptions. It sits between the ID/EXE control logic and the PC register. Instruction fetch is addressed from that register.

## Interface
Parameters:
- EXC_VEC, 32'h8000_0180, general exception vector (kseg0)
- REFILL_VEC, 32'h8000_0000, TLB-refill vector (kseg0)

Ports:
- clk  in  1  clock, rising edge
- clrn  in  1  reset, asynchronous, active-low
- pc  in  32  current PC register value
- if_ready  in  1  fetch accepted this cycle (ITLB hit, memory ready)
- stall  in  1  pipeline hazard stall; PC must hold
- br_req  in  1  taken branch or jump resolved in ID
- br_target  in  32  its target
- exc  in  1  exception request from EXE/MEM
- exc_refill  in  1  exception is a TLB refill; selects REFILL_VEC
- exc_pc  in  32  PC of the faulting instruction
- exc_bd  in  1  faulting instruction is in a branch delay slot
- eret  in  1  ERET committed
- epc_in  in  32  current CP0 EPC
- npc  out  32  next PC, driven to the PC register's d
- pc_we  out  1  PC register enable
- flush  out  1  squash IF/ID/EXE
- epc  out  32  EPC value to write
- epc_we  out  1  CP0 EPC write strobe

## Operation
- The FSM has four states: BOOT, RUN, PEND, FLUSH. Reset state is BOOT.
- Request priority is exc > eret > pending redirect > br_req > sequential.
- exc, in any state and regardless of stall or if_ready:
  - npc = exc_refill ? REFILL_VEC : EXC_VEC; pc_we=1; flush=1; epc_we=1.
  - epc = exc_bd ? exc_pc-4 : exc_pc, modulo 2^32.
  - The pending register is cleared; next state is FLUSH.
- eret, with no exc: npc=epc_in; pc_we=1; flush=1; pending is cleared; next state is FLUSH.
- BOOT: pc_we=0 for one cycle, so the first fetch is the reset PC. Next state is RUN.
- RUN:
  - br_req with !stall and if_ready: npc=br_target, pc_we=1.
  - br_req with stall or !if_ready: br_target is latched into the pending register; next state is PEND; pc_we=0.
  - Otherwise npc=pc+4 (32-bit wrap, 32'hFFFF_FFFC+4=0); pc_we = if_ready & !stall.
- PEND:
  - npc = pending target; pc_we = if_ready & !stall.
  - When written, next state is RUN.
  - br_req arriving while in PEND is ignored; the ID stage is stalled, so it is the same request.
- FLUSH: exactly one cycle.
  - br_req is ignored; it comes from a squashed instruction.
  - Sequential rules apply.
  - Next state is RUN, or FLUSH again if exc or eret is asserted.
- exc and eret together: exc wins; eret is dropped.
- Reset mid-operation: all state returns to BOOT and the pending register is cleared.

## Timing
- npc, pc_we, flush, epc and epc_we are combinational from the inputs and the registered state. The PC updates at the next rising clk edge, so redirect latency is 1 cycle.
- A stalled redirect is applied in the first cycle with if_ready & !stall, taking 1 cycle after the stall releases.
- Registered elements are state and pend_target only.
- Reset values: state=BOOT, pend_target=0.
- Output values during reset: pc_we=0, flush=0, epc_we=0, epc=0, npc=32'h8000_0000.
- epc_we is a 1-cycle pulse per exc cycle.

## Structure
- Shared package `cpu_pkg`:
  - state enum `pcs_state_t` (BOOT, RUN, PEND, FLUSH)
  - EXC_VEC and REFILL_VEC defaults
  - constant `RESET_PC` = 32'h8000_0000
- One sub-module, `pc_next_mux`: a purely combinational priority select of npc and pc_we from the request vector.
- The FSM and pending register stay in `pc_sequencer`.

## Test plan
- Reset release, pc=32'h8000_0000, if_ready=1: BOOT cycle has pc_we=0. The next cycle has npc=32'h8000_0004, pc_we=1.
- br_req, br_target=32'h8000_0100, with stall=1 for 3 cycles: pc_we=0 for those 3 cycles. The first unstalled cycle has npc=32'h8000_0100, pc_we=1, and the state returns to RUN.
- exc with exc_pc=32'h8000_0040, exc_bd=1, stall=1: npc=32'h8000_0180, pc_we=1, flush=1, epc=32'h8000_003C, epc_we=1. A br_req in the following cycle is ignored.
- exc_refill=1 and eret=1 together with exc: npc=32'h8000_0000, epc_we=1, and eret has no effect.
- eret with epc_in=32'h8000_2000 while a redirect is pending: npc=32'h8000_2000, flush=1, and the pending target is discarded.
- pc=32'hFFFF_FFFC, sequential: npc=32'h0000_0000. Asserting clrn low mid-PEND returns the block to BOOT with pending cleared.
